// File: rtl/monitor_saida.sv
// rtl/monitor_saida.sv - change-detecting capture FIFO for the CPU valor_saida bus
module monitor_saida #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valor_saida,
  input  logic                       captura_en,
  input  logic                       leitura_req,
  output logic                       dado_valido,
  output logic [WIDTH-1:0]           dado_saida,
  output logic [$clog2(DEPTH):0]     contagem,
  output logic                       cheio,
  output logic                       vazio,
  output logic                       overflow,
  output logic [7:0]                 descartados
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] anterior;
  logic             primado;

  logic evento;
  logic pop;
  logic push;
  logic drop;

  // A capture is a change relative to the last sampled value, or the first sample after reset
  assign evento = captura_en && (!primado || (valor_saida != anterior));
  assign pop    = leitura_req && dado_valido;
  assign push   = evento && (!cheio || pop);
  assign drop   = evento && cheio && !pop;

  assign vazio       = (contagem == '0);
  assign cheio       = (contagem == CW'(DEPTH));
  assign dado_valido = !vazio;
  assign dado_saida  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= valor_saida;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      contagem    <= '0;
      anterior    <= '0;
      primado     <= 1'b0;
      overflow    <= 1'b0;
      descartados <= '0;
    end else begin
      // The reference value follows the bus whenever sampling is enabled, even for dropped captures
      if (captura_en) begin
        anterior <= valor_saida;
        primado  <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        contagem <= contagem + CW'(1);
      end else if (pop && !push) begin
        contagem <= contagem - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (descartados != 8'hFF) begin
          descartados <= descartados + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_monitor_saida.sv
// tb/tb_monitor_saida.sv - directed self-checking bench for monitor_saida
module tb_monitor_saida;

  logic        clock;
  logic        reset;
  logic [31:0] valor_saida;
  logic        captura_en;
  logic        leitura_req;
  logic        dado_valido;
  logic [31:0] dado_saida;
  logic [3:0]  contagem;
  logic        cheio;
  logic        vazio;
  logic        overflow;
  logic [7:0]  descartados;

  int n_tests = 0;
  int n_fail  = 0;

  monitor_saida #(.WIDTH(32), .DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .valor_saida (valor_saida),
    .captura_en  (captura_en),
    .leitura_req (leitura_req),
    .dado_valido (dado_valido),
    .dado_saida  (dado_saida),
    .contagem    (contagem),
    .cheio       (cheio),
    .vazio       (vazio),
    .overflow    (overflow),
    .descartados (descartados)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cen;
    logic [31:0] val;
    logic        rd;
    logic        chk_d;
    logic [31:0] dado;
    logic [3:0]  cont;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cen, input logic [31:0] val, input logic rd,
                              input logic chk_d, input logic [31:0] dado, input logic [3:0] cont);
    vec_t v;
    v.cen = cen; v.val = val; v.rd = rd; v.chk_d = chk_d; v.dado = dado; v.cont = cont;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    captura_en = 1'b0;
    leitura_req = 1'b0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic fill_1_to_8();
    captura_en = 1'b1;
    leitura_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      valor_saida = 32'(i);
      step();
    end
  endtask

  int q[$];
  int exp_drain[$];

  initial begin
    reset = 1'b1;
    valor_saida = '0;
    captura_en = 1'b0;
    leitura_req = 1'b0;

    // Reset defaults
    do_reset(2);
    chk("rst_contagem", 32'(contagem), 0);
    chk("rst_vazio", 32'(vazio), 1);
    chk("rst_cheio", 32'(cheio), 0);
    chk("rst_valido", 32'(dado_valido), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_descartados", 32'(descartados), 0);

    // Constant zero after reset is captured exactly once
    captura_en = 1'b1;
    valor_saida = 32'd0;
    repeat (5) step();
    chk("zero_contagem", 32'(contagem), 1);
    chk("zero_dado", dado_saida, 0);
    chk("zero_valido", 32'(dado_valido), 1);

    // Change detection, empty pops, disabled-sampling hold
    do_reset(1);
    tbl.push_back(mk(1, 5, 0, 1, 5, 1));
    tbl.push_back(mk(1, 5, 0, 1, 5, 1));
    tbl.push_back(mk(1, 7, 0, 1, 5, 2));
    tbl.push_back(mk(1, 7, 0, 1, 5, 2));
    tbl.push_back(mk(1, 7, 0, 1, 5, 2));
    tbl.push_back(mk(1, 9, 0, 1, 5, 3));
    tbl.push_back(mk(0, 9, 1, 1, 7, 2));
    tbl.push_back(mk(0, 9, 1, 1, 9, 1));
    tbl.push_back(mk(0, 9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 9, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 1, 4, 1));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      captura_en = tbl[i].cen;
      valor_saida = tbl[i].val;
      leitura_req = tbl[i].rd;
      step();
      chk($sformatf("vec%0d_contagem", i), 32'(contagem), 32'(tbl[i].cont));
      chk($sformatf("vec%0d_vazio", i), 32'(vazio), 32'(tbl[i].cont == 0));
      chk($sformatf("vec%0d_valido", i), 32'(dado_valido), 32'(tbl[i].cont != 0));
      if (tbl[i].chk_d) chk($sformatf("vec%0d_dado", i), dado_saida, tbl[i].dado);
    end

    // Full, overflow, simultaneous push/pop at full, drain
    do_reset(1);
    fill_1_to_8();
    chk("full_cheio", 32'(cheio), 1);
    chk("full_contagem", 32'(contagem), 8);
    valor_saida = 32'd10; step();
    valor_saida = 32'd11; step();
    chk("ovf_overflow", 32'(overflow), 1);
    chk("ovf_descartados", 32'(descartados), 2);
    chk("ovf_head", dado_saida, 1);
    chk("ovf_contagem", 32'(contagem), 8);
    valor_saida = 32'd20;
    leitura_req = 1'b1;
    step();
    chk("simul_contagem", 32'(contagem), 8);
    chk("simul_descartados", 32'(descartados), 2);
    chk("simul_head", dado_saida, 2);
    captura_en = 1'b0;
    exp_drain = '{2, 3, 4, 5, 6, 7, 8, 20};
    for (int i = 0; i < exp_drain.size(); i++) begin
      chk($sformatf("drain%0d", i), dado_saida, 32'(exp_drain[i]));
      step();
    end
    chk("drain_vazio", 32'(vazio), 1);
    leitura_req = 1'b0;

    // Drop-counter saturation, then pointer wrap with push+pop each cycle
    do_reset(1);
    fill_1_to_8();
    for (int i = 0; i < 300; i++) begin
      valor_saida = 32'(100 + i);
      step();
    end
    chk("sat_descartados", 32'(descartados), 255);
    chk("sat_overflow", 32'(overflow), 1);
    chk("sat_head", dado_saida, 1);
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    leitura_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      valor_saida = 32'(500 + k);
      chk($sformatf("wrap%0d_head", k), dado_saida, 32'(q[0]));
      step();
      void'(q.pop_front());
      q.push_back(500 + k);
    end
    chk("wrap_contagem", 32'(contagem), 8);
    leitura_req = 1'b0;
    valor_saida = 32'd999;
    step();
    chk("sat_hold_descartados", 32'(descartados), 255);
    chk("sat_hold_head", dado_saida, 32'(q[0]));

    // Reset mid-operation with 4 queued, empty pops, fresh capture
    captura_en = 1'b0;
    leitura_req = 1'b1;
    repeat (4) step();
    chk("mid_contagem4", 32'(contagem), 4);
    reset = 1'b1;
    captura_en = 1'b1;
    valor_saida = 32'h77;
    step();
    reset = 1'b0;
    captura_en = 1'b0;
    leitura_req = 1'b0;
    chk("mid_rst_contagem", 32'(contagem), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_descartados", 32'(descartados), 0);
    leitura_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("empty_pop%0d_contagem", i), 32'(contagem), 0);
      chk($sformatf("empty_pop%0d_valido", i), 32'(dado_valido), 0);
    end
    leitura_req = 1'b0;
    captura_en = 1'b1;
    valor_saida = 32'h1234;
    step();
    chk("post_rst_dado", dado_saida, 32'h1234);
    chk("post_rst_contagem", 32'(contagem), 1);
    chk("post_rst_valido", 32'(dado_valido), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_saida.md
# monitor_saida

Capture block on the far side of the processor's `valor_saida` output bus: it reads every change of the CPU result value into a small FIFO, so a bench or downstream logic can drain the values at its own pace. It sits beside `cpu`, taking `valor_saida` as input and exposing a pop handshake plus FIFO status and loss accounting. All state is updated on the rising edge of `clock`.

## Interface
- `WIDTH`, 32, width of captured value (matches `valor_saida`)
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `clock`  input  1  single system clock, rising edge
- `reset`  input  1  synchronous, active-high reset
- `valor_saida`  input  WIDTH  CPU result value being monitored
- `captura_en`  input  1  capture enable; sampling only when high
- `leitura_req`  input  1  pop request from consumer
- `dado_valido`  output  1  FIFO non-empty; `dado_saida` holds the oldest entry
- `dado_saida`  output  WIDTH  head entry (show-ahead)
- `contagem`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `cheio`  output  1  occupancy == DEPTH
- `vazio`  output  1  occupancy == 0
- `overflow`  output  1  sticky: at least one capture dropped since reset
- `descartados`  output  8  dropped-capture count, saturates at 255

## Operation
- Internal `anterior` register (WIDTH) and `primado` flag; both cleared by reset.
- Capture event in a cycle when `captura_en`=1 AND (`primado`=0 OR `valor_saida` != `anterior`).
- When `captura_en`=1: `anterior` <= `valor_saida`, `primado` <= 1 at the edge, whether or not the push is accepted.
- When `captura_en`=0: no capture; `anterior`/`primado` hold (a value changing and changing back while disabled is not captured).
- Push: capture event and (not full, or pop accepted in the same cycle). Writes `valor_saida` at the write pointer.
- Pop: `leitura_req`=1 and `dado_valido`=1. `leitura_req` while empty is ignored; no state change.
- Simultaneous push and pop: both performed; `contagem` unchanged. When full, the pop frees the slot and the push is accepted.
- Capture event while full without a pop: value dropped, `overflow` <= 1, `descartados` increments unless already 255. FIFO contents unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately in `contagem`.
- `cheio`, `vazio`, and `dado_valido` are derived from `contagem`. `dado_saida` is memory[read pointer]; its value is don't-care when empty.

## Timing
- Reset (`reset`=1 at an edge):
  - `contagem`=0, `vazio`=1, `cheio`=0, `dado_valido`=0.
  - `overflow`=0, `descartados`=0.
  - Pointers=0, `primado`=0, `anterior`=0.
  - `dado_saida` = memory[0] (contents not cleared; don't-care).
- Reset has priority over everything in the same cycle: a capture or pop asserted during reset is lost. Reset mid-stream discards all queued entries.
- Capture latency: value sampled at edge N into an empty FIFO gives `dado_valido`=1 and `dado_saida`=value after edge N.
- Pop latency: pop at edge N gives the next entry (or `dado_valido`=0) after edge N.
- Status outputs are registered or derived from registers; no combinational path from `valor_saida` or `leitura_req` to any output.
- Throughput: one push and one pop per cycle.

## Test plan
- **Reset defaults:** hold `reset` 2 cycles → all status outputs at reset values. Then `captura_en`=1 with `valor_saida`=0 constant for 5 cycles → exactly one entry (0), `contagem`=1.
- **Change detection:** `captura_en`=1; `valor_saida` sequence 5, 5, 7, 7, 7, 9 → entries 5, 7, 9 in order, `contagem`=3. Pop 3 times → `dado_saida` 5, 7, 9, then `vazio`=1.
- **Full/overflow:** DEPTH=8; push 1..8 with no pops → `cheio`=1. Push 10, 11 → `overflow`=1, `descartados`=2, head still 1. Drain → 1..8 only.
- **Simultaneous at full:** full with 1..8; same cycle new value 20 and `leitura_req`=1 → `contagem` stays 8, `descartados` unchanged, drained order 2..8, 20.
- **Saturation and wrap-around:** keep full, present 300 distinct values → `descartados`=255. Then alternate single push/pop for 20 cycles → data order preserved across pointer wrap.
- **Reset mid-operation and empty pop:** with 4 entries queued, assert `reset` 1 cycle → `contagem`=0, `overflow`=0. `leitura_req`=1 while empty for 3 cycles → no change. Next capture of 0x1234 → `dado_saida`=0x1234.
